// File: rtl/int_to_float_pkg.sv
// Shared floating-point definitions for the integer/single/double converter chain.
// Holds the handshake FSM encoding, IEEE-754 field geometry and packing helpers.
package int_to_float_pkg;

    typedef enum logic [2:0] {
        get_a       = 3'd0,
        convert_0   = 3'd1,
        normalise_0 = 3'd2,
        round_0     = 3'd3,
        pack_0      = 3'd4,
        put_z       = 3'd5
    } state_t;

    localparam int SINGLE_W       = 32;
    localparam int SINGLE_EXP_W   = 8;
    localparam int SINGLE_MAN_W   = 23;
    localparam int SINGLE_SIGN_POS = 31;
    localparam int SINGLE_EXP_LSB = 23;

    localparam int DOUBLE_W       = 64;
    localparam int DOUBLE_EXP_W   = 11;
    localparam int DOUBLE_MAN_W   = 52;
    localparam int DOUBLE_SIGN_POS = 63;
    localparam int DOUBLE_EXP_LSB = 52;

    localparam logic [SINGLE_EXP_W-1:0] SINGLE_BIAS = 8'd127;
    localparam logic [DOUBLE_EXP_W-1:0] DOUBLE_BIAS = 11'd1023;

    localparam logic [SINGLE_W-1:0] FLOAT_ZERO = 32'h0000_0000;

    // Exponent is passed unbiased; the hidden bit is not part of the fraction.
    function automatic logic [SINGLE_W-1:0] pack_single(
        input logic                    sign,
        input logic [SINGLE_EXP_W-1:0] exp_unbiased,
        input logic [SINGLE_MAN_W-1:0] frac
    );
        return {sign, exp_unbiased + SINGLE_BIAS, frac};
    endfunction

endpackage

// File: rtl/int_to_float.sv
// Serial int32 -> IEEE-754 single converter, round to nearest even.
// One normalise shift per clock; stb/ack handshake on both sides.
module int_to_float
    import int_to_float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    state_t                  state_q;
    logic [31:0]             a_q;
    logic [31:0]             v_q;
    logic                    s_q;
    logic [SINGLE_EXP_W-1:0] e_q;
    logic [23:0]             m_q;
    logic [SINGLE_W-1:0]     z_q;

    logic [31:0]             a_mag_d;
    logic [23:0]             m_trunc;
    logic                    guard_bit;
    logic                    round_bit;
    logic                    sticky_bit;
    logic                    round_up;
    logic [24:0]             m_sum;
    logic [23:0]             m_d;
    logic [SINGLE_EXP_W-1:0] e_d;

    // -2^31 negates to itself, which read as unsigned is the right magnitude.
    assign a_mag_d = a_q[31] ? (~a_q + 32'd1) : a_q;

    always_comb begin
        m_trunc    = v_q[31:8];
        guard_bit  = v_q[7];
        round_bit  = v_q[6];
        sticky_bit = |v_q[5:0];
        round_up   = guard_bit && (round_bit || sticky_bit || m_trunc[0]);
        m_sum      = {1'b0, m_trunc} + {24'd0, round_up};
        m_d        = m_sum[23:0];
        e_d        = e_q;
        if (m_sum[24]) begin
            m_d = 24'h80_0000;
            e_d = e_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= get_a;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= FLOAT_ZERO;
        end else begin
            case (state_q)
                get_a: begin
                    input_a_ack <= 1'b1;
                    if (input_a_ack && input_a_stb) begin
                        a_q         <= input_a;
                        input_a_ack <= 1'b0;
                        state_q     <= convert_0;
                    end
                end
                convert_0: begin
                    if (a_q == 32'd0) begin
                        z_q     <= FLOAT_ZERO;
                        state_q <= put_z;
                    end else begin
                        s_q     <= a_q[31];
                        v_q     <= a_mag_d;
                        e_q     <= 8'd31;
                        state_q <= normalise_0;
                    end
                end
                normalise_0: begin
                    if (!v_q[31]) begin
                        v_q <= {v_q[30:0], 1'b0};
                        e_q <= e_q - 8'd1;
                    end else begin
                        state_q <= round_0;
                    end
                end
                round_0: begin
                    m_q     <= m_d;
                    e_q     <= e_d;
                    state_q <= pack_0;
                end
                pack_0: begin
                    z_q     <= pack_single(s_q, e_q, m_q[SINGLE_MAN_W-1:0]);
                    state_q <= put_z;
                end
                put_z: begin
                    output_z_stb <= 1'b1;
                    output_z     <= z_q;
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state_q      <= get_a;
                    end
                end
                default: begin
                    state_q <= get_a;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Self-checking bench for int_to_float: directed corner cases plus a randomized
// handshake stream checked against an arithmetic int->single->double model.
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] input_a = 32'd0;
    logic        input_a_stb = 1'b0;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    int_to_float dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;

    // Reference: find the leading one, keep 24 bits, round the discarded tail.
    function automatic logic [31:0] ref_single(input logic [31:0] a);
        longint mag;
        longint q;
        longint rem;
        longint half;
        int     p;
        int     sh;
        logic   sign;
        logic [7:0] be;
        if (a == 32'd0) return 32'd0;
        mag  = longint'($signed(a));
        sign = (mag < 0);
        if (mag < 0) mag = -mag;
        p = 31;
        while (((mag >> p) & 64'd1) == 64'd0) p--;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh   = p - 23;
            rem  = mag % (64'sd1 <<< sh);
            half = 64'sd1 <<< (sh - 1);
            q    = mag >> sh;
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
            if (q == (64'sd1 <<< 24)) begin
                q = q >> 1;
                p++;
            end
        end
        be = 8'(p + 127);
        return {sign, be, q[22:0]};
    endfunction

    // Bench model of the downstream float_to_double stage (field remap).
    function automatic logic [63:0] f2d(input logic [31:0] f);
        logic [10:0] de;
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        de = {3'd0, f[30:23]} + 11'd896;
        return {f[31], de, f[22:0], 29'd0};
    endfunction

    // Independent double reference: decode the single as a real number.
    function automatic logic [63:0] ref_double(input logic [31:0] f);
        real r;
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        r = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(int'(f[30:23]) - 127));
        if (f[31]) r = -r;
        return $realtobits(r);
    endfunction

    task automatic send(input logic [31:0] v, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        input_a     = v;
        input_a_stb = 1'b1;
        while (!input_a_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = input_a_ack;
        @(posedge clk);
        #1 input_a_stb = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (output_z_stb) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({input_a_ack, output_z_stb, output_z} !== {1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b stb=%b z=%h, required 0 0 00000000",
                     input_a_ack, output_z_stb, output_z);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (input_a_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ack: ack=%b, required 1", input_a_ack);
        end
    endtask

    task automatic test_values();
        logic [31:0] vin [7] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd16777217, 32'd16777219,
                                 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] vexp[7] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h4B80_0000,
                                 32'h4B80_0002, 32'h4F00_0000, 32'hCF00_0000};
        int          vlat[7] = '{36, 36, 2, 12, 12, 6, 5};
        int lat;
        bit ok;
        for (int i = 0; i < 7; i++) begin
            send(vin[i], ok);
            wait_out(lat, ok);
            n_cmp++;
            if (!ok || lat != vlat[i]) begin
                n_fail++;
                $display("FAIL latency_%h: got %0d cycles (seen=%0b), required %0d",
                         vin[i], lat, ok, vlat[i]);
            end
            n_cmp++;
            if (output_z !== vexp[i]) begin
                n_fail++;
                $display("FAIL value_%h: got %h, required %h", vin[i], output_z, vexp[i]);
            end
            output_z_ack = 1'b1;
            @(posedge clk);
            #1 output_z_ack = 1'b0;
            n_cmp++;
            if (output_z_stb !== 1'b0) begin
                n_fail++;
                $display("FAIL stb_drop_%h: stb=%b, required 0", vin[i], output_z_stb);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        bit ok;
        logic [31:0] held;
        send(32'd100, ok);
        wait_out(lat, ok);
        held = output_z;
        n_cmp++;
        if (held !== 32'h42C8_0000) begin
            n_fail++;
            $display("FAIL stall_value: got %h, required 42c80000", held);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (output_z_stb !== 1'b1 || output_z !== held || input_a_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: stb=%b z=%h ack=%b, required 1 %h 0",
                         c, output_z_stb, output_z, input_a_ack, held);
            end
        end
        output_z_ack = 1'b1;
        @(posedge clk);
        #1 output_z_ack = 1'b0;
        n_cmp++;
        if (output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: stb=%b ack=%b, required 0 0", output_z_stb, input_a_ack);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (input_a_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_ack_return: ack=%b, required 1", input_a_ack);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok;
        bit spurious;
        send(32'd1, ok);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({input_a_ack, output_z_stb, output_z} !== {1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: ack=%b stb=%b z=%h, required 0 0 00000000",
                     input_a_ack, output_z_stb, output_z);
        end
        rst = 1'b1;
        spurious = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (output_z_stb) spurious = 1'b1;
        end
        n_cmp++;
        if (spurious) begin
            n_fail++;
            $display("FAIL reset_mid_no_output: output_z_stb rose after reset, required 0");
        end
        send(32'd3, ok);
        wait_out(lat, ok);
        n_cmp++;
        if (!ok || output_z !== 32'h4040_0000 || lat != 35) begin
            n_fail++;
            $display("FAIL reset_mid_next: z=%h lat=%0d, required 40400000 35", output_z, lat);
        end
        output_z_ack = 1'b1;
        @(posedge clk);
        #1 output_z_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        localparam int N = 1000;
        localparam int BUDGET = 70000;
        logic [31:0] exp_q[$];
        int sent = 0;
        int recv = 0;
        fork
            begin : producer
                int  guard = 0;
                bit  fired = 1'b0;
                logic [31:0] v;
                while (sent < N && guard < BUDGET) begin
                    @(negedge clk);
                    guard++;
                    if (fired) begin
                        input_a_stb = 1'b0;
                        fired = 1'b0;
                    end
                    if (!input_a_stb && $urandom_range(0, 2) == 0) begin
                        case ($urandom_range(0, 15))
                            0:       v = 32'd0;
                            1:       v = 32'h8000_0000;
                            2:       v = 32'h7FFF_FFFF;
                            default: begin
                                v = $urandom >> $urandom_range(0, 31);
                                if ($urandom_range(0, 1) == 1) v = -v;
                            end
                        endcase
                        input_a     = v;
                        input_a_stb = 1'b1;
                    end
                    if (input_a_stb && input_a_ack) begin
                        exp_q.push_back(input_a);
                        sent++;
                        fired = 1'b1;
                    end
                end
                @(negedge clk);
                input_a_stb = 1'b0;
            end
            begin : consumer
                int  guard = 0;
                bit  pending = 1'b0;
                logic [31:0] prev_z = 32'd0;
                logic [31:0] a;
                logic [31:0] es;
                while (recv < N && guard < BUDGET) begin
                    @(negedge clk);
                    guard++;
                    if (pending) begin
                        n_cmp++;
                        if (output_z_stb !== 1'b1 || output_z !== prev_z) begin
                            n_fail++;
                            $display("FAIL b2b_hold: stb=%b z=%h, required 1 %h",
                                     output_z_stb, output_z, prev_z);
                        end
                    end
                    output_z_ack = ($urandom_range(0, 2) != 0);
                    if (output_z_stb && output_z_ack) begin
                        pending = 1'b0;
                        recv++;
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL b2b_duplicate: output %h with no pending input", output_z);
                        end else begin
                            a  = exp_q.pop_front();
                            es = ref_single(a);
                            if (output_z !== es) begin
                                n_fail++;
                                $display("FAIL b2b_single_%h: got %h, required %h", a, output_z, es);
                            end
                            n_cmp++;
                            if (f2d(output_z) !== ref_double(es)) begin
                                n_fail++;
                                $display("FAIL b2b_double_%h: got %h, required %h",
                                         a, f2d(output_z), ref_double(es));
                            end
                        end
                    end else begin
                        pending = output_z_stb;
                        prev_z  = output_z;
                    end
                end
                @(negedge clk);
                output_z_ack = 1'b0;
            end
        join
        n_cmp++;
        if (sent != N || recv != N || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: sent=%0d received=%0d left=%0d, required %0d %0d 0",
                     sent, recv, exp_q.size(), N, N);
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/int_to_float.md
Name: int_to_float

Overview:
- Converts a 32-bit two's-complement signed integer into an IEEE-754 single-precision value.
- Rounds to nearest, ties to even.
- Sits directly upstream of the float-to-double converter and drives it over the same stb/ack handshake, so integer sources can reach the double-precision datapath.
- Multi-cycle and serial: one normalise shift per clock, so area stays small.

Parameters:
- none

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- input_a  in  32  signed integer operand
- input_a_stb  in  1  upstream asserts: input_a valid
- input_a_ack  out  1  block ready; transfer when input_a_ack && input_a_stb on a clk edge
- output_z  out  32  IEEE-754 single result
- output_z_stb  out  1  output_z valid
- output_z_ack  in  1  downstream accepts; transfer when output_z_stb && output_z_ack

Behaviour:
- Reset (rst==0 at clk edge, overrides all other assignments that cycle): state=get_a, input_a_ack=0, output_z_stb=0, output_z=0. Internal registers are don't-care. Reset mid-conversion abandons the operand; no output is produced for it.
- States: get_a, convert_0, normalise_0, round_0, pack_0, put_z.
- get_a:
  - drive input_a_ack=1 from the cycle after entry.
  - On ack&&stb: latch a=input_a, drop ack, go to convert_0.
  - Ack is never high in any other state.
- convert_0:
  - If a==0: z=32'h00000000, go to put_z.
  - Else: s=a[31]; v=s ? -a : a, as 32-bit unsigned (-2^31 yields 32'h80000000, correct). e=31. Go to normalise_0.
- normalise_0:
  - If v[31]==0: v<<=1, e-=1, stay.
  - Else go to round_0.
  - Loop count equals the leading-zero count of |a|, range 0..31.
- round_0:
  - m=v[31:8] (24 bits incl. hidden 1); g=v[7]; r=v[6]; st=|v[5:0].
  - If g && (r||st||m[0]): m+=1.
  - If the increment carries out (m was 24'hFFFFFF), m=24'h800000 and e+=1.
  - Go to pack_0.
- pack_0: z={s, e+8'd127, m[22:0]}; go to put_z. Exponent never overflows (max e=31), so no inf/NaN/denormal output is possible.
- put_z:
  - output_z_stb=1, output_z=z.
  - On output_z_stb && output_z_ack: stb=0, go to get_a.
  - output_z holds its value until the next put_z.
  - output_z_stb never drops without ack.
- Latency from input transfer edge to first output_z_stb high:
  - 3 + lz + 2 cycles for nonzero input (lz = leading zeros of |a|).
  - 2 cycles for zero.
  - Max 36.
- Throughput: one conversion in flight; a new input is accepted no earlier than one cycle after the output transfer.
- A simultaneous stb and ack on the same edge as entry to get_a does not transfer, because ack is still 0.

Decomposition:
- Shared fp package holds:
  - state encodings
  - SINGLE_BIAS=127, DOUBLE_BIAS=1023
  - single/double field widths and positions
  - FLOAT_ZERO constant
- These are reused by the float_to_double stage and later converters.
- No sub-module; round-to-nearest-even logic is inline. A later double_to_float stage may factor it out as round_nearest_even.

Test Plan:
- Values: 1 -> 32'h3F800000 after 36 cycles; -1 -> 32'hBF800000; 0 -> 32'h00000000 after 2 cycles.
- Ties-to-even: 16777217 (2^24+1) -> 32'h4B800000 (round down); 16777219 -> 32'h4B800002 (round up).
- Mantissa carry: 2147483647 -> 32'h4F000000, exponent incremented. -2147483648 -> 32'hCF000000.
- Handshake stall: hold output_z_ack=0 for 20 cycles. output_z_stb stays 1, output_z stays stable, and input_a_ack stays 0 throughout. Then ack -> stb drops next edge, and input_a_ack rises one cycle later.
- Reset mid-operation: drive rst=0 during normalise_0 of input 1. Next edge: state get_a, both stb/ack = 0, output_z = 0. No output appears; the next input 3 -> 32'h40400000.
- Back-to-back chain into float_to_double: 1000 random ints compared against a reference model of int->single->double conversion. No lost or duplicated transfers.
